bj_game_ctrl: RTL

Round controller for the FPGA blackjack game, directly downstream of the top-level KEY synchronizer. It consumes the synchronized, active-low `start`, `hit` and `stand` button levels and detects presses. It deals cards from a free-running LFSR and tracks player and dealer hands with soft-ace scoring. It plays the dealer to 17 and publishes scores, the last dealt card and the round result to the HEX/VGA display logic.

---
 rtl/bj_pkg.sv | 36 +++
 rtl/card_lfsr.sv | 33 +++
 rtl/bj_game_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bj_pkg.sv
// Shared types, scoring constants and card helpers for the blackjack round controller.
package bj_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER,
        P_HIT,
        DEALER,
        RESULT
    } state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        WIN  = 2'd1,
        LOSE = 2'd2,
        PUSH = 2'd3
    } result_t;

    localparam logic [4:0] BJ_TARGET    = 5'd21;
    localparam logic [4:0] DEALER_STAND = 5'd17;
    localparam logic [4:0] ACE_BONUS    = 5'd10;

    // Face cards (J/Q/K) count as 10; an ace counts 1 in the hard sum.
    function automatic logic [4:0] card_value(input logic [3:0] rank);
        return (rank >= 4'd10) ? 5'd10 : {1'b0, rank};
    endfunction

    function automatic logic [4:0] hand_score(input logic [4:0] hard, input logic has_ace);
        return (has_ace && (hard <= 5'd11)) ? hard + ACE_BONUS : hard;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) and the card rank drawn from it.
module card_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state,
    output logic [3:0]  rank
);

    logic [15:0] lfsr_reg;
    logic        feedback;
    logic [3:0]  nibble;

    assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], feedback};
        end
    end

    // Fold 13..15 back onto 0..2 so every nibble maps to a rank 1..13.
    always_comb begin
        nibble = lfsr_reg[3:0];
        rank   = ((nibble >= 4'd13) ? nibble - 4'd13 : nibble) + 4'd1;
    end

    assign state = lfsr_reg;

endmodule

// File: rtl/bj_game_ctrl.sv
// Blackjack round controller: button press detection, dealing, hand scoring,
// dealer auto-play and round result, all outputs registered.
module bj_game_ctrl
    import bj_pkg::*;
#(
    parameter int          DEALER_DELAY = 25_000_000,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic       stand,
    output logic [4:0] player_score,
    output logic [4:0] dealer_score,
    output logic       dealer_hidden,
    output logic [3:0] card_rank,
    output logic       card_to_player,
    output logic       card_valid,
    output logic [1:0] result
);

    localparam int CW = (DEALER_DELAY > 1) ? $clog2(DEALER_DELAY) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEALER_DELAY - 1);

    state_t        state_reg, state_next;
    logic          start_prev_reg, hit_prev_reg, stand_prev_reg;
    logic          start_press, hit_press, stand_press;
    logic [4:0]    p_hard_reg, p_hard_next, d_hard_reg, d_hard_next;
    logic          p_ace_reg, p_ace_next, d_ace_reg, d_ace_next;
    logic [4:0]    player_score_reg, player_score_next;
    logic [4:0]    dealer_score_reg, dealer_score_next;
    logic          hidden_reg, hidden_next;
    logic [3:0]    card_rank_reg, card_rank_next;
    logic          card_to_player_reg, card_to_player_next;
    logic          card_valid_reg, card_valid_next;
    result_t       result_reg, result_next;
    logic [CW-1:0] count_reg, count_next;

    logic [15:0]   lfsr_state;
    logic [3:0]    draw_rank;
    logic          deal_player, deal_dealer;
    logic [4:0]    p_deal_hard, d_deal_hard, p_deal_score;
    logic          p_deal_ace, d_deal_ace;

    card_lfsr #(
        .SEED(LFSR_SEED)
    ) u_card_lfsr (
        .clk  (clk),
        .rst  (rst),
        .state(lfsr_state),
        .rank (draw_rank)
    );

    // Inputs are active-low levels; a press is the 1 -> 0 transition.
    assign start_press = start_prev_reg & ~start;
    assign hit_press   = hit_prev_reg   & ~hit;
    assign stand_press = stand_prev_reg & ~stand;

    always_comb begin
        p_deal_hard  = p_hard_reg + card_value(draw_rank);
        p_deal_ace   = p_ace_reg | (draw_rank == 4'd1);
        p_deal_score = hand_score(p_deal_hard, p_deal_ace);
        d_deal_hard  = d_hard_reg + card_value(draw_rank);
        d_deal_ace   = d_ace_reg | (draw_rank == 4'd1);
    end

    always_comb begin
        state_next          = state_reg;
        p_hard_next         = p_hard_reg;
        p_ace_next          = p_ace_reg;
        d_hard_next         = d_hard_reg;
        d_ace_next          = d_ace_reg;
        hidden_next         = hidden_reg;
        result_next         = result_reg;
        count_next          = count_reg;
        card_rank_next      = card_rank_reg;
        card_to_player_next = card_to_player_reg;
        card_valid_next     = 1'b0;
        deal_player         = 1'b0;
        deal_dealer         = 1'b0;

        case (state_reg)
            IDLE, RESULT: begin
                if (start_press) begin
                    state_next  = DEAL_P1;
                    p_hard_next = '0;
                    p_ace_next  = 1'b0;
                    d_hard_next = '0;
                    d_ace_next  = 1'b0;
                    result_next = NONE;
                    hidden_next = 1'b1;
                end
            end
            DEAL_P1: begin
                deal_player = 1'b1;
                state_next  = DEAL_D1;
            end
            DEAL_D1: begin
                deal_dealer = 1'b1;
                state_next  = DEAL_P2;
            end
            DEAL_P2: begin
                deal_player = 1'b1;
                state_next  = DEAL_D2;
            end
            DEAL_D2: begin
                deal_dealer = 1'b1;
                if (player_score_reg == BJ_TARGET) begin
                    state_next  = DEALER;
                    hidden_next = 1'b0;
                    count_next  = '0;
                end else begin
                    state_next  = PLAYER;
                end
            end
            PLAYER: begin
                // Stand is checked first so a simultaneous hit is dropped.
                if (stand_press) begin
                    state_next  = DEALER;
                    hidden_next = 1'b0;
                    count_next  = '0;
                end else if (hit_press) begin
                    state_next  = P_HIT;
                end
            end
            P_HIT: begin
                deal_player = 1'b1;
                if (p_deal_score > BJ_TARGET) begin
                    state_next  = RESULT;
                    result_next = LOSE;
                end else if (p_deal_score == BJ_TARGET) begin
                    state_next  = DEALER;
                    hidden_next = 1'b0;
                    count_next  = '0;
                end else begin
                    state_next  = PLAYER;
                end
            end
            DEALER: begin
                if (count_reg == COUNT_LAST) begin
                    count_next = '0;
                    if (dealer_score_reg < DEALER_STAND) begin
                        deal_dealer = 1'b1;
                    end else begin
                        state_next = RESULT;
                        if (dealer_score_reg > BJ_TARGET) begin
                            result_next = WIN;
                        end else if (player_score_reg > dealer_score_reg) begin
                            result_next = WIN;
                        end else if (player_score_reg < dealer_score_reg) begin
                            result_next = LOSE;
                        end else begin
                            result_next = PUSH;
                        end
                    end
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (deal_player) begin
            p_hard_next = p_deal_hard;
            p_ace_next  = p_deal_ace;
        end
        if (deal_dealer) begin
            d_hard_next = d_deal_hard;
            d_ace_next  = d_deal_ace;
        end
        if (deal_player || deal_dealer) begin
            card_valid_next     = 1'b1;
            card_rank_next      = draw_rank;
            card_to_player_next = deal_player;
        end

        // Scores are registered from the next-hand values so they move with card_valid.
        player_score_next = hand_score(p_hard_next, p_ace_next);
        dealer_score_next = hand_score(d_hard_next, d_ace_next);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            start_prev_reg     <= 1'b1;
            hit_prev_reg       <= 1'b1;
            stand_prev_reg     <= 1'b1;
            p_hard_reg         <= '0;
            p_ace_reg          <= 1'b0;
            d_hard_reg         <= '0;
            d_ace_reg          <= 1'b0;
            player_score_reg   <= '0;
            dealer_score_reg   <= '0;
            hidden_reg         <= 1'b0;
            card_rank_reg      <= '0;
            card_to_player_reg <= 1'b0;
            card_valid_reg     <= 1'b0;
            result_reg         <= NONE;
            count_reg          <= '0;
        end else begin
            state_reg          <= state_next;
            start_prev_reg     <= start;
            hit_prev_reg       <= hit;
            stand_prev_reg     <= stand;
            p_hard_reg         <= p_hard_next;
            p_ace_reg          <= p_ace_next;
            d_hard_reg         <= d_hard_next;
            d_ace_reg          <= d_ace_next;
            player_score_reg   <= player_score_next;
            dealer_score_reg   <= dealer_score_next;
            hidden_reg         <= hidden_next;
            card_rank_reg      <= card_rank_next;
            card_to_player_reg <= card_to_player_next;
            card_valid_reg     <= card_valid_next;
            result_reg         <= result_next;
            count_reg          <= count_next;
        end
    end

    assign player_score   = player_score_reg;
    assign dealer_score   = dealer_score_reg;
    assign dealer_hidden  = hidden_reg;
    assign card_rank      = card_rank_reg;
    assign card_to_player = card_to_player_reg;
    assign card_valid     = card_valid_reg;
    assign result         = result_reg;

endmodule
